// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cacheline adaptor.
// A 256-bit cacheline moves as four 64-bit beats on the physical-memory bus.
package cacheline_adaptor_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;

  typedef logic [S_LINE-1:0]  llc_cacheline;
  typedef logic [S_BURST-1:0] burst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_t;

  localparam logic [31:0] OFFSET_MASK = (32'd1 << S_OFFSET) - 32'd1;

  // Align a byte address down to the start of its cacheline.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline adaptor.
// The adaptor uses the slave modport; the driving environment uses master.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  // cache side
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  llc_cacheline line_i;
  llc_cacheline line_o;
  logic         resp_o;

  // physical-memory side
  burst_t       burst_i;
  burst_t       burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one 256-bit line read/write into a four-beat
// 64-bit burst and buffers the whole line in both directions.
// Optional feature: define CACHELINE_ADAPTOR_PERF_CNT_EN to add the
// perf_rd_o / perf_wr_o completed-transaction counters.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  ,
  output logic [31:0]         perf_rd_o,
  output logic [31:0]         perf_wr_o
`endif
);

  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  adaptor_state_t                    r_state;
  logic [1:0]                        r_beat;
  logic [NUM_BEATS-1:0][S_BURST-1:0] r_buf;
  logic [31:0]                       r_addr;
  logic                              r_read;
  logic                              r_write;
  logic                              r_resp;

  // Request capture, beat sequencing and the registered bus handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= 2'd0;
      r_buf   <= '0;
      r_addr  <= 32'd0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // read wins over a simultaneous write; the write line is not latched
          if (bus.read_i) begin
            r_addr  <= line_addr(bus.address_i);
            r_read  <= 1'b1;
            r_state <= RD;
          end else if (bus.write_i) begin
            r_addr  <= line_addr(bus.address_i);
            r_buf   <= bus.line_i;
            r_write <= 1'b1;
            r_state <= WR;
          end else begin
            r_state <= IDLE;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            r_buf[r_beat] <= bus.burst_i;
            r_beat        <= r_beat + 2'd1;
            if (r_beat == LAST_BEAT) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= RD;
            end
          end else begin
            r_state <= RD;
          end
        end
        WR: begin
          if (bus.resp_i) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == LAST_BEAT) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= WR;
            end
          end else begin
            r_state <= WR;
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_beat  <= 2'd0;
          r_state <= IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_resp  <= 1'b0;
          r_beat  <= 2'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.resp_o    = r_resp;
  assign bus.address_o = r_addr;
  assign bus.line_o    = r_buf;
  // the write beat follows the beat counter directly so memory sees it the same cycle
  assign bus.burst_o   = r_buf[r_beat];

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  logic        r_op_wr;
  logic [31:0] r_perf_rd;
  logic [31:0] r_perf_wr;

  // Remember the accepted operation and count it once in its DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_wr   <= 1'b0;
      r_perf_rd <= 32'd0;
      r_perf_wr <= 32'd0;
    end else begin
      if (r_state == IDLE) begin
        if (bus.read_i) begin
          r_op_wr <= 1'b0;
        end else if (bus.write_i) begin
          r_op_wr <= 1'b1;
        end else begin
          r_op_wr <= r_op_wr;
        end
      end else if (r_state == DONE) begin
        if (r_op_wr) begin
          r_perf_wr <= r_perf_wr + 32'd1;
        end else begin
          r_perf_rd <= r_perf_rd + 32'd1;
        end
      end else begin
        r_op_wr <= r_op_wr;
      end
    end
  end

  assign perf_rd_o = r_perf_rd;
  assign perf_wr_o = r_perf_wr;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed cases plus randomized
// transactions with random memory stalls, checked against a line-level model.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus();

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  logic [31:0] perf_rd;
  logic [31:0] perf_wr;
  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .perf_rd_o (perf_rd),
    .perf_wr_o (perf_wr)
  );
`else
  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  bit resp_seq[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic burst_t rand_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic llc_cacheline rand_line();
    return {rand_beat(), rand_beat(), rand_beat(), rand_beat()};
  endfunction

  // One line transaction, starting and ending at a falling edge with the DUT idle.
  // abort_at >= 0 pulls reset once that many beats have been transferred.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input llc_cacheline wline, input bit fixed,
                        input int stall_pct, input int abort_at);
    burst_t       beats[4];
    llc_cacheline exp_line;
    logic [31:0]  exp_addr;
    bit           is_rd;
    bit           r;
    int           k;
    int           cyc;
    is_rd    = rd;
    exp_addr = {addr[31:5], 5'b0};
    for (int i = 0; i < 4; i++) beats[i] = fixed ? {16{4'(i + 1)}} : rand_beat();
    exp_line = is_rd ? {beats[3], beats[2], beats[1], beats[0]} : wline;

    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = wline;
    bus.resp_i    = 1'($urandom_range(0, 1));
    bus.burst_i   = rand_beat();
    @(negedge clk);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = $urandom;
    bus.line_i    = rand_line();

    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 200) begin
      if (abort_at >= 0 && k == abort_at) begin
        bus.resp_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_read_o",  bus.read_o,    1'b0);
        check_eq("rst_write_o", bus.write_o,   1'b0);
        check_eq("rst_resp_o",  bus.resp_o,    1'b0);
        check_eq("rst_addr_o",  bus.address_o, 32'd0);
        check_eq("rst_line_o",  bus.line_o,    256'd0);
        check_eq("rst_burst_o", bus.burst_o,   64'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      check_eq("busy_read_o",  bus.read_o,    is_rd);
      check_eq("busy_write_o", bus.write_o,   !is_rd);
      check_eq("busy_resp_o",  bus.resp_o,    1'b0);
      check_eq("busy_addr_o",  bus.address_o, exp_addr);
      if (!is_rd) check_eq("burst_o", bus.burst_o, wline[k*64 +: 64]);
      if (resp_seq.size() > 0) r = resp_seq.pop_front();
      else r = ($urandom_range(0, 99) >= stall_pct);
      bus.resp_i  = r;
      bus.burst_i = r ? beats[k] : rand_beat();
      if (r) k++;
      cyc++;
      @(negedge clk);
    end
    check_eq("beats_done", k, 4);

    // DONE cycle: responses from memory must be ignored here
    bus.resp_i  = 1'($urandom_range(0, 1));
    bus.burst_i = rand_beat();
    check_eq("done_resp_o",  bus.resp_o,    1'b1);
    check_eq("done_read_o",  bus.read_o,    1'b0);
    check_eq("done_write_o", bus.write_o,   1'b0);
    check_eq("done_addr_o",  bus.address_o, exp_addr);
    check_eq("done_line_o",  bus.line_o,    exp_line);
    @(negedge clk);
    if (is_rd) exp_rd++;
    else exp_wr++;
    check_eq("post_resp_o", bus.resp_o, 1'b0);
    check_eq("post_line_o", bus.line_o, exp_line);
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    check_eq("perf_rd", perf_rd, 32'(exp_rd));
    check_eq("perf_wr", perf_wr, 32'(exp_wr));
`endif
    bus.resp_i = 1'b0;
  endtask

  // Idle cycles with stray memory responses that must be ignored.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.resp_i  = 1'($urandom_range(0, 1));
      bus.burst_i = rand_beat();
      @(negedge clk);
      check_eq("idle_resp_o",  bus.resp_o,  1'b0);
      check_eq("idle_read_o",  bus.read_o,  1'b0);
      check_eq("idle_write_o", bus.write_o, 1'b0);
    end
    bus.resp_i = 1'b0;
  endtask

  initial begin
    llc_cacheline wl;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = 32'd0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_read_o",  bus.read_o,    1'b0);
    check_eq("reset_write_o", bus.write_o,   1'b0);
    check_eq("reset_resp_o",  bus.resp_o,    1'b0);
    check_eq("reset_addr_o",  bus.address_o, 32'd0);
    check_eq("reset_line_o",  bus.line_o,    256'd0);
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    check_eq("reset_perf_rd", perf_rd, 32'd0);
    check_eq("reset_perf_wr", perf_wr, 32'd0);
`endif
    rst = 1'b1;
    idle_gap(2);

    // directed read, no stalls, fixed 0x11.. / 0x22.. / 0x33.. / 0x44.. beats
    do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b1, 0, -1);
    check_eq("dir_rd_line", bus.line_o,
             256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    check_eq("dir_rd_addr", bus.address_o, 32'h0000_1220);
    idle_gap(2);

    // directed write, DEAD_BEEF pattern with beat index in the low nibble
    wl = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
          64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    do_txn(1'b0, 1'b1, 32'h0000_8000, wl, 1'b0, 0, -1);
    idle_gap(1);

    // read with stall pattern 1,0,0,1,0,1,1
    resp_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_txn(1'b1, 1'b0, 32'hABCD_EF5F, '0, 1'b0, 0, -1);
    check_eq("pattern_consumed", resp_seq.size(), 0);
    idle_gap(1);

    // simultaneous read and write: read only
    do_txn(1'b1, 1'b1, 32'h0000_4040, rand_line(), 1'b0, 30, -1);
    idle_gap(1);

    // reset after two beats of a read, then a fresh read
    do_txn(1'b1, 1'b0, 32'h1111_2222, '0, 1'b0, 0, 2);
    idle_gap(3);
    do_txn(1'b1, 1'b0, 32'h3333_4444, '0, 1'b0, 0, -1);

    // back-to-back eviction write and refill read
    do_txn(1'b0, 1'b1, 32'h0000_A0E0, rand_line(), 1'b0, 20, -1);
    do_txn(1'b1, 1'b0, 32'h0000_B0C0, '0, 1'b0, 20, -1);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      bit rd_r;
      bit wr_r;
      rd_r = 1'($urandom_range(0, 1));
      wr_r = rd_r ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(rd_r, wr_r, $urandom, rand_line(), 1'b0, $urandom_range(0, 60), -1);
      idle_gap($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
